// File: rtl/note_sequencer.sv
// Eight-step note sequencer: plays {period, duration} entries in order,
// feeding a wave generator with a period and a gate, with optional looping.
module note_sequencer #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [2:0]  last_step,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_period,
  input  logic [15:0] wr_dur,
  output logic [31:0] period,
  output logic        gate,
  output logic [2:0]  step_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 32'd1);

  state_t      state_r, state_nx;
  logic [31:0] tbl_period [8];
  logic [15:0] tbl_dur [8];
  logic [15:0] presc_r, presc_nx;
  logic [15:0] dur_r, dur_nx;
  logic [2:0]  last_r, last_nx;
  logic [2:0]  step_nx;
  logic [31:0] period_nx;
  logic        gate_nx;
  logic        done_nx;
  logic [31:0] ld_period_s;
  logic [15:0] ld_dur_s;

  assign ld_period_s = tbl_period[step_idx];
  assign ld_dur_s    = tbl_dur[step_idx];
  assign busy        = (state_r != IDLE);

  // Step table; the playing step keeps its own copy, so writes never disturb it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_period[wr_addr] <= wr_period;
      tbl_dur[wr_addr]    <= wr_dur;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx  = state_r;
    presc_nx  = presc_r;
    dur_nx    = dur_r;
    last_nx   = last_r;
    step_nx   = step_idx;
    period_nx = period;
    gate_nx   = gate;
    done_nx   = 1'b0;
    if (stop) begin
      state_nx  = IDLE;
      presc_nx  = 16'd0;
      dur_nx    = 16'd0;
      step_nx   = 3'd0;
      period_nx = 32'd0;
      gate_nx   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            last_nx  = last_step;
            step_nx  = 3'd0;
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
        LOAD: begin
          period_nx = ld_period_s;
          gate_nx   = (ld_period_s != 32'd0);
          dur_nx    = (ld_dur_s == 16'd0) ? 16'd1 : ld_dur_s;
          presc_nx  = 16'd0;
          state_nx  = PLAY;
        end
        PLAY: begin
          if (presc_r == PRESC_MAX) begin
            presc_nx = 16'd0;
            if (dur_r == 16'd1) begin
              dur_nx = 16'd0;
              if (step_idx != last_r) begin
                step_nx  = step_idx + 3'd1;
                state_nx = LOAD;
              end else if (loop_en) begin
                step_nx  = 3'd0;
                state_nx = LOAD;
              end else begin
                state_nx  = IDLE;
                period_nx = 32'd0;
                gate_nx   = 1'b0;
                done_nx   = 1'b1;
              end
            end else begin
              dur_nx = dur_r - 16'd1;
            end
          end else begin
            presc_nx = presc_r + 16'd1;
          end
        end
        default: begin
          state_nx  = IDLE;
          step_nx   = 3'd0;
          period_nx = 32'd0;
          gate_nx   = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      presc_r  <= 16'd0;
      dur_r    <= 16'd0;
      last_r   <= 3'd0;
      step_idx <= 3'd0;
      period   <= 32'd0;
      gate     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_nx;
      presc_r  <= presc_nx;
      dur_r    <= dur_nx;
      last_r   <= last_nx;
      step_idx <= step_nx;
      period   <= period_nx;
      gate     <= gate_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a cycle-countdown model checked every
// cycle, plus hand-computed expectations at fixed edges after start.
module tb_note_sequencer;

  localparam int unsigned TD = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        stop      = 1'b0;
  logic        loop_en   = 1'b0;
  logic [2:0]  last_step = 3'd0;
  logic        wr_en     = 1'b0;
  logic [2:0]  wr_addr   = 3'd0;
  logic [31:0] wr_period = 32'd0;
  logic [15:0] wr_dur    = 16'd0;
  logic [31:0] period;
  logic        gate;
  logic [2:0]  step_idx;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int rel   = 0;

  // model: busy flag, load flag and remaining PLAY cycles
  logic        m_busy, m_load, m_done, m_gate;
  logic [31:0] m_period;
  logic [2:0]  m_step, m_last;
  int          m_rem;
  logic [31:0] mt_period [8];
  logic [15:0] mt_dur [8];

  note_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .last_step(last_step), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_period(wr_period), .wr_dur(wr_dur), .period(period), .gate(gate),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) begin
      mt_period[wr_addr] <= wr_period;
      mt_dur[wr_addr]    <= wr_dur;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_load <= 1'b0; m_done <= 1'b0; m_gate <= 1'b0;
      m_period <= 32'd0; m_step <= 3'd0; m_last <= 3'd0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (stop) begin
        m_busy <= 1'b0; m_load <= 1'b0; m_period <= 32'd0; m_gate <= 1'b0; m_step <= 3'd0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1; m_load <= 1'b1; m_step <= 3'd0; m_last <= last_step;
        end
      end else if (m_load) begin
        m_load   <= 1'b0;
        m_period <= mt_period[m_step];
        m_gate   <= (mt_period[m_step] != 32'd0);
        m_rem    <= ((mt_dur[m_step] == 16'd0) ? 1 : int'(mt_dur[m_step])) * int'(TD);
      end else if (m_rem > 1) begin
        m_rem <= m_rem - 1;
      end else if (m_step != m_last) begin
        m_step <= m_step + 3'd1; m_load <= 1'b1;
      end else if (loop_en) begin
        m_step <= 3'd0; m_load <= 1'b1;
      end else begin
        m_busy <= 1'b0; m_period <= 32'd0; m_gate <= 1'b0; m_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (rel %0d): got %0d, expected %0d", name, rel, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("model.period", period, m_period);
    chk("model.gate", 32'(gate), 32'(m_gate));
    chk("model.busy", 32'(busy), 32'(m_busy));
    chk("model.done", 32'(done), 32'(m_done));
    if (m_busy) chk("model.step_idx", 32'(step_idx), 32'(m_step));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rel++;
      compare_all();
    end
  endtask

  task automatic run_to(input int k);
    while (rel < k) run(1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] p, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_period = p; wr_dur = d;
    run(1);
    wr_en = 1'b0;
  endtask

  // raise start just after edge E0 so that E1 samples it
  task automatic go();
    start = 1'b1;
    rel = 0;
    run(1);
    start = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".busy"}, 32'(busy), 32'd0);
    chk({name, ".gate"}, 32'(gate), 32'd0);
    chk({name, ".period"}, period, 32'd0);
    chk({name, ".done"}, 32'(done), 32'd0);
    chk({name, ".step_idx"}, 32'(step_idx), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 chk_idle("reset");
    run(2);
    reset = 1'b0;
    run(2);

    // two-step program, single pass
    wr(3'd0, 32'd64, 16'd1);
    wr(3'd1, 32'd128, 16'd2);
    last_step = 3'd1; loop_en = 1'b0;
    run(1);
    go();
    run_to(2);  chk("e2.period", period, 32'd64); chk("e2.gate", 32'(gate), 32'd1);
    run_to(7);  chk("e7.period", period, 32'd128); chk("e7.step_idx", 32'(step_idx), 32'd1);
    run_to(14); chk("e14.busy", 32'(busy), 32'd1); chk("e14.done", 32'(done), 32'd0);
    run_to(15); chk("e15.done", 32'(done), 32'd1); chk("e15.busy", 32'(busy), 32'd0);
    chk("e15.period", period, 32'd0); chk("e15.gate", 32'(gate), 32'd0);
    run_to(16); chk("e16.done", 32'(done), 32'd0);

    // rest step
    wr(3'd0, 32'd0, 16'd1);
    last_step = 3'd0;
    run(1);
    go();
    run_to(2); chk("rest.gate", 32'(gate), 32'd0); chk("rest.busy", 32'(busy), 32'd1);
    run_to(5); chk("rest.gate5", 32'(gate), 32'd0); chk("rest.done5", 32'(done), 32'd0);
    run_to(6); chk("rest.done", 32'(done), 32'd1);

    // zero duration plays as one unit
    wr(3'd0, 32'd100, 16'd0);
    go();
    run_to(2); chk("dur0.period", period, 32'd100);
    run_to(5); chk("dur0.busy5", 32'(busy), 32'd1);
    run_to(6); chk("dur0.done", 32'(done), 32'd1);

    // looping with a rewrite of the playing step
    wr(3'd0, 32'd64, 16'd1);
    last_step = 3'd1; loop_en = 1'b1;
    run(1);
    go();
    run_to(16); chk("loop.e16.period", period, 32'd64); chk("loop.e16.step", 32'(step_idx), 32'd0);
    run_to(21); chk("loop.e21.period", period, 32'd128); chk("loop.e21.step", 32'(step_idx), 32'd1);
    run_to(22);
    wr(3'd1, 32'd200, 16'd1);
    run_to(25); chk("loop.e25.period", period, 32'd128);
    run_to(30); chk("loop.e30.period", period, 32'd64); chk("loop.e30.step", 32'(step_idx), 32'd0);
    run_to(35); chk("loop.e35.period", period, 32'd200); chk("loop.e35.step", 32'(step_idx), 32'd1);
    run_to(36);
    loop_en = 1'b0;
    run_to(38); chk("loop.e38.busy", 32'(busy), 32'd1);
    run_to(39); chk("loop.e39.done", 32'(done), 32'd1); chk("loop.e39.busy", 32'(busy), 32'd0);

    // stop during step1, then start+stop together
    wr(3'd1, 32'd128, 16'd2);
    run(1);
    go();
    run_to(8); chk("stop.e8.step", 32'(step_idx), 32'd1);
    stop = 1'b1;
    run_to(9); chk_idle("stop");
    start = 1'b1;
    run_to(11); chk("startstop.busy", 32'(busy), 32'd0);
    start = 1'b0; stop = 1'b0;
    run(2);

    // asynchronous reset mid-PLAY, then replay retained program
    go();
    run_to(4); chk("prereset.period", period, 32'd64); chk("prereset.gate", 32'(gate), 32'd1);
    #2 reset = 1'b1;
    #1 chk_idle("midreset");
    run(2);
    reset = 1'b0;
    run(2);
    go();
    run_to(2);  chk("replay.e2.period", period, 32'd64);
    run_to(7);  chk("replay.e7.period", period, 32'd128);
    run_to(15); chk("replay.e15.done", 32'(done), 32'd1);
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
